instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
Fetch-stage block and the producer end of the 16-bit IR interface that the decode stage consumes (IR[15:12] opcode, IR[11:0] value). It holds the program counter, reads instruction memory through a req/ack handshake, and presents IR with a valid/ready handshake. It also handles jump redirects, the global halt_program freeze, and the HALT opcode.

Parameters:
ADDR_W, 12, PC and instruction-memory address width (matches the 12-bit value field)
DATA_W, 16, instruction width
HALT_OP, 4'hF, opcode that stops fetching once it is delivered

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
halt_program  input  1  global freeze
imem_req  output  1  memory read request
imem_addr  output  ADDR_W  read address
imem_rdata  input  DATA_W  read data, valid when imem_ack=1
imem_ack  input  1  one-cycle read completion
jump_en  input  1  redirect request, one-cycle pulse
jump_addr  input  ADDR_W  redirect target
IR  output  DATA_W  instruction to the decoder
ir_valid  output  1  IR holds a deliverable instruction
ir_ready  input  1  decoder accepts IR this cycle
PC  output  ADDR_W  address of the next instruction to fetch
halted  output  1  HALT_OP has been delivered
instr_count  output  16  delivered-instruction count, saturating

Behaviour:
- Reset (rst=0, asynchronous) forces: PC=0, IR=0, ir_valid=0, imem_req=0, imem_addr=0, halted=0, instr_count=0, kill=0, state=FETCH. Asserting reset mid-transaction abandons the transaction; a late imem_ack is ignored.
- States:
  - FETCH: issue a read for PC.
  - WAIT: wait for imem_ack.
  - DELIVER: hold IR until the decoder accepts it.
  - HALTED: stop fetching.
- FETCH:
  - If halt_program=0, drive imem_req=1 and imem_addr=PC, then go to WAIT next cycle.
  - If halt_program=1, stay in FETCH with imem_req=0.
- WAIT:
  - imem_req and imem_addr stay constant until the cycle imem_ack=1 is sampled. imem_req drops in the following cycle.
  - On ack with kill=0: IR<=imem_rdata, ir_valid<=1, go to DELIVER. Minimum latency is req to ir_valid in 2 cycles with a zero-wait ack.
  - On ack with kill=1: discard the data, clear kill, go to FETCH.
- DELIVER:
  - IR and ir_valid are held until ir_valid&&ir_ready.
  - On the handshake cycle: ir_valid<=0, instr_count increments (saturates at 16'hFFFF), PC<=PC+1 (wraps from 12'hFFF to 12'h000).
  - After the handshake: if IR[15:12]==HALT_OP, go to HALTED and set halted<=1; otherwise go to FETCH.
- HALTED:
  - No requests are issued and all outputs are held.
  - Only reset exits this state; jump_en is ignored.
- jump_en=1, in any state except HALTED, sets PC<=jump_addr.
  - In FETCH: the next request uses jump_addr.
  - In WAIT: set kill=1; the outstanding read completes and is dropped, then the target is fetched.
  - In DELIVER: ir_valid<=0 immediately (flush), no count, go to FETCH, even if ir_ready=1 in the same cycle.
  - A jump in the ack cycle of WAIT behaves as kill: the data is discarded.
- halt_program=1:
  - Blocks new requests and blocks the DELIVER handshake (ir_ready is ignored).
  - An outstanding WAIT read still completes and IR is captured.
  - Jumps are still recorded.
  - Deasserting halt_program resumes on the next cycle.
- Simultaneous events:
  - jump beats handshake.
  - halt_program beats the handshake and the new request.
  - reset beats everything.

Test Plan:
- Reset, memory returns 16'h1234 at addr 0 with ack one cycle after req; ir_ready=1 -> imem_req rises the cycle after reset release; IR=16'h1234 and ir_valid=1 two cycles after req; after the handshake PC=1 and instr_count=1.
- Hold ir_ready=0 for 5 cycles with IR=16'h2ABC -> IR and ir_valid stable, PC=0, no new imem_req; ir_ready=1 -> single handshake, PC=1.
- Start with PC=12'hFFF, ack data 16'h3001, ir_ready=1 -> PC wraps to 12'h000, next imem_addr=0.
- Pulse jump_en with jump_addr=12'h040 while in WAIT, then ack with 16'h5555 -> 16'h5555 never appears with ir_valid=1; next imem_addr=12'h040.
- Pulse jump_en (jump_addr=12'h010) together with ir_ready in DELIVER -> ir_valid=0, instr_count unchanged, next imem_addr=12'h010.
- Deliver 16'hF000 with ir_ready=1 -> halted=1, imem_req stays 0 for 20 cycles with jump_en pulsed; assert rst=0 mid-WAIT on a fresh run -> all outputs 0 immediately.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle.
//   imem_req/imem_addr     : read request toward instruction memory
//   imem_rdata/imem_ack    : read completion (ack is a one-cycle pulse)
//   IR/ir_valid/ir_ready   : instruction handed to the decoder (valid/ready)
// master: the fetch block. slave: memory + decoder side.
interface instr_fetch_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 16
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              imem_ack;
  logic [DATA_W-1:0] IR;
  logic              ir_valid;
  logic              ir_ready;

  modport master (
    output imem_req, imem_addr, IR, ir_valid,
    input  imem_rdata, imem_ack, ir_ready
  );

  modport slave (
    input  imem_req, imem_addr, IR, ir_valid,
    output imem_rdata, imem_ack, ir_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: holds the PC, reads instruction memory over a
// req/ack handshake and hands each instruction to the decoder over valid/ready.
// Handles jump redirects, the global halt_program freeze and the HALT opcode.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   halt_program      : freeze (blocks new requests and the decoder handshake)
//   bus (master)      : imem_* read channel and IR/ir_valid/ir_ready channel
//   jump_en/jump_addr : one-cycle redirect
//   PC                : address of the next instruction to fetch
//   halted            : HALT_OP has been delivered; only reset leaves this
//   instr_count       : delivered instructions, saturating
module instr_fetch #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DATA_W  = 16,
  parameter logic [3:0]  HALT_OP = 4'hF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt_program,
  instr_fetch_if.master     bus,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [ADDR_W-1:0] PC,
  output logic              halted,
  output logic [15:0]       instr_count
);

  typedef enum logic [1:0] {StFetch, StWait, StDeliver, StHalted} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              ir_valid_q, ir_valid_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              halted_q, halted_d;
  logic [15:0]       cnt_q, cnt_d;
  // Set when a jump lands while a read is outstanding; the returning data is stale.
  logic              kill_q, kill_d;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    req_d      = req_q;
    addr_d     = addr_q;
    halted_d   = halted_q;
    cnt_d      = cnt_q;
    kill_d     = kill_q;

    case (state_q)
      StFetch: begin
        if (jump_en) pc_d = jump_addr;
        if (!halt_program) begin
          // A same-cycle jump redirects this very request.
          req_d   = 1'b1;
          addr_d  = jump_en ? jump_addr : pc_q;
          state_d = StWait;
        end
      end

      StWait: begin
        if (jump_en) pc_d = jump_addr;
        if (bus.imem_ack) begin
          req_d = 1'b0;
          if (kill_q || jump_en) begin
            kill_d  = 1'b0;
            state_d = StFetch;
          end else begin
            ir_d       = bus.imem_rdata;
            ir_valid_d = 1'b1;
            state_d    = StDeliver;
          end
        end else if (jump_en) begin
          kill_d = 1'b1;
        end
      end

      StDeliver: begin
        if (jump_en) begin
          // Flush: jump wins over a same-cycle handshake.
          pc_d       = jump_addr;
          ir_valid_d = 1'b0;
          state_d    = StFetch;
        end else if (!halt_program && ir_valid_q && bus.ir_ready) begin
          ir_valid_d = 1'b0;
          cnt_d      = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
          pc_d       = pc_q + ADDR_W'(1);
          if (ir_q[DATA_W-1 -: 4] == HALT_OP) begin
            halted_d = 1'b1;
            state_d  = StHalted;
          end else begin
            state_d = StFetch;
          end
        end
      end

      StHalted: ;

      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StFetch;
      pc_q       <= '0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      halted_q   <= 1'b0;
      cnt_q      <= '0;
      kill_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      halted_q   <= halted_d;
      cnt_q      <= cnt_d;
      kill_q     <= kill_d;
    end
  end

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = addr_q;
  assign bus.IR        = ir_q;
  assign bus.ir_valid  = ir_valid_q;
  assign PC            = pc_q;
  assign halted        = halted_q;
  assign instr_count   = cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios followed by a randomized run
// checked against a transaction-level model of PC, count and delivered data.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        halt_program;
  logic        jump_en;
  logic [11:0] jump_addr;
  logic [11:0] PC;
  logic        halted;
  logic [15:0] instr_count;

  instr_fetch_if #(.ADDR_W(12), .DATA_W(16)) bus ();

  instr_fetch #(.ADDR_W(12), .DATA_W(16), .HALT_OP(4'hF)) dut (
    .clk          (clk),
    .rst          (rst),
    .halt_program (halt_program),
    .bus          (bus),
    .jump_en      (jump_en),
    .jump_addr    (jump_addr),
    .PC           (PC),
    .halted       (halted),
    .instr_count  (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [15:0] mem [4096];
  bit          rand_wait = 1'b0;
  int          wcnt      = 0;
  int          cur_wait  = 0;

  // Memory: acks a request after cur_wait extra cycles, one-cycle ack pulse.
  initial begin
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
  end
  always @(posedge clk) begin
    bus.imem_ack <= 1'b0;
    if (bus.imem_req && !bus.imem_ack) begin
      if (wcnt >= cur_wait) begin
        bus.imem_ack   <= 1'b1;
        bus.imem_rdata <= mem[bus.imem_addr];
        wcnt           <= 0;
        cur_wait       <= rand_wait ? int'($urandom_range(0, 2)) : 0;
      end else begin
        wcnt <= wcnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cyc(1);
    rst = 1'b1;
  endtask

  logic [11:0] m_pc;
  logic [15:0] m_cnt;
  logic        m_halted;
  logic        prev_req;
  logic        prev_halt;
  logic [15:0] word;

  initial begin
    rst          = 1'b1;
    halt_program = 1'b0;
    jump_en      = 1'b0;
    jump_addr    = '0;
    bus.ir_ready = 1'b1;
    for (int i = 0; i < 4096; i++) mem[i] = '0;

    // Reset state.
    #2 rst = 1'b0;
    cyc(2);
    check("rst_pc", PC, 0);
    check("rst_ir", bus.IR, 0);
    check("rst_valid", bus.ir_valid, 0);
    check("rst_req", bus.imem_req, 0);
    check("rst_addr", bus.imem_addr, 0);
    check("rst_halted", halted, 0);
    check("rst_cnt", instr_count, 0);

    // First fetch, zero-wait memory, ready held high.
    mem[0] = 16'h1234;
    rst = 1'b1;
    cyc(1);
    check("t1_req_rise", bus.imem_req, 1);
    check("t1_addr", bus.imem_addr, 0);
    check("t1_valid_early", bus.ir_valid, 0);
    cyc(1);
    check("t1_req_hold", bus.imem_req, 1);
    check("t1_valid_early2", bus.ir_valid, 0);
    cyc(1);
    check("t1_valid", bus.ir_valid, 1);
    check("t1_ir", bus.IR, 16'h1234);
    check("t1_req_drop", bus.imem_req, 0);
    cyc(1);
    check("t1_valid_clr", bus.ir_valid, 0);
    check("t1_pc", PC, 1);
    check("t1_cnt", instr_count, 1);

    // Back-pressure from the decoder.
    mem[0] = 16'h2ABC;
    mem[1] = 16'h4321;
    bus.ir_ready = 1'b0;
    do_reset();
    cyc(3);
    for (int i = 0; i < 5; i++) begin
      check("t2_ir", bus.IR, 16'h2ABC);
      check("t2_valid", bus.ir_valid, 1);
      check("t2_pc", PC, 0);
      check("t2_req", bus.imem_req, 0);
      cyc(1);
    end
    bus.ir_ready = 1'b1;
    cyc(1);
    check("t2_valid_clr", bus.ir_valid, 0);
    check("t2_pc1", PC, 1);
    check("t2_cnt1", instr_count, 1);
    bus.ir_ready = 1'b0;
    cyc(6);
    check("t2_cnt_single", instr_count, 1);
    check("t2_ir_next", bus.IR, 16'h4321);

    // Jump together with ready in DELIVER: flush, no count.
    mem[0] = 16'h6000;
    do_reset();
    cyc(3);
    check("t5_valid", bus.ir_valid, 1);
    jump_en = 1'b1; jump_addr = 12'h010; bus.ir_ready = 1'b1;
    cyc(1);
    jump_en = 1'b0; bus.ir_ready = 1'b0;
    check("t5_flush", bus.ir_valid, 0);
    check("t5_cnt", instr_count, 0);
    check("t5_pc", PC, 12'h010);
    cyc(1);
    check("t5_req", bus.imem_req, 1);
    check("t5_addr", bus.imem_addr, 12'h010);

    // Jump while WAIT: outstanding data is dropped.
    mem[12'h010] = 16'h5555;
    mem[12'h040] = 16'h7040;
    jump_en = 1'b1; jump_addr = 12'h040;
    cyc(1);
    jump_en = 1'b0;
    check("t4_pc", PC, 12'h040);
    check("t4_valid0", bus.ir_valid, 0);
    cyc(1);
    check("t4_valid1", bus.ir_valid, 0);
    check("t4_req_off", bus.imem_req, 0);
    cyc(1);
    check("t4_req", bus.imem_req, 1);
    check("t4_addr", bus.imem_addr, 12'h040);
    check("t4_valid2", bus.ir_valid, 0);
    cyc(2);
    check("t4_valid3", bus.ir_valid, 1);
    check("t4_ir", bus.IR, 16'h7040);

    // PC wrap from 12'hFFF.
    mem[12'hFFF] = 16'h3001;
    jump_en = 1'b1; jump_addr = 12'hFFF;
    cyc(1);
    jump_en = 1'b0;
    check("t3_pc_fff", PC, 12'hFFF);
    bus.ir_ready = 1'b1;
    cyc(1);
    check("t3_addr_fff", bus.imem_addr, 12'hFFF);
    cyc(2);
    check("t3_valid", bus.ir_valid, 1);
    check("t3_ir", bus.IR, 16'h3001);
    cyc(1);
    check("t3_pc_wrap", PC, 12'h000);
    check("t3_cnt", instr_count, 1);
    cyc(1);
    check("t3_req", bus.imem_req, 1);
    check("t3_addr_wrap", bus.imem_addr, 12'h000);

    // halt_program: blocks requests and the handshake, not an outstanding read.
    mem[0] = 16'h1111;
    halt_program = 1'b1;
    bus.ir_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check("hp_no_req", bus.imem_req, 0);
    end
    halt_program = 1'b0;
    cyc(1);
    check("hp_req", bus.imem_req, 1);
    halt_program = 1'b1;
    cyc(2);
    check("hp_captured", bus.ir_valid, 1);
    check("hp_ir", bus.IR, 16'h1111);
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check("hp_hold_valid", bus.ir_valid, 1);
      check("hp_hold_cnt", instr_count, 0);
    end
    halt_program = 1'b0;
    cyc(1);
    check("hp_resume_valid", bus.ir_valid, 0);
    check("hp_resume_cnt", instr_count, 1);

    // HALT opcode.
    mem[0] = 16'hF000;
    bus.ir_ready = 1'b1;
    do_reset();
    cyc(3);
    check("h_ir", bus.IR, 16'hF000);
    cyc(1);
    check("h_halted", halted, 1);
    check("h_valid", bus.ir_valid, 0);
    check("h_cnt", instr_count, 1);
    check("h_pc", PC, 1);
    for (int i = 0; i < 20; i++) begin
      jump_en   = (i % 2 == 0);
      jump_addr = 12'h055;
      cyc(1);
      check("h_no_req", bus.imem_req, 0);
    end
    jump_en = 1'b0;
    check("h_pc_hold", PC, 1);
    check("h_still", halted, 1);
    check("h_ir_hold", bus.IR, 16'hF000);

    // Reset mid-WAIT, with the ack arriving while reset is low.
    mem[0]       = 16'h7777;
    mem[12'h123] = 16'h2123;
    do_reset();
    jump_en = 1'b1; jump_addr = 12'h123;
    cyc(1);
    jump_en = 1'b0;
    check("r_addr", bus.imem_addr, 12'h123);
    check("r_pc", PC, 12'h123);
    cyc(1);
    rst = 1'b0;
    #1;
    check("r_req0", bus.imem_req, 0);
    check("r_addr0", bus.imem_addr, 0);
    check("r_pc0", PC, 0);
    check("r_valid0", bus.ir_valid, 0);
    check("r_ir0", bus.IR, 0);
    check("r_cnt0", instr_count, 0);
    check("r_halted0", halted, 0);
    cyc(2);
    rst = 1'b1;
    cyc(3);
    check("r_after_valid", bus.ir_valid, 1);
    check("r_after_ir", bus.IR, 16'h7777);

    // Randomized run against the transaction-level model.
    for (int i = 0; i < 4096; i++) begin
      word = 16'($urandom);
      if (word[15:12] == 4'hF) word[15:12] = 4'h0;
      mem[i] = word;
    end
    rand_wait    = 1'b1;
    halt_program = 1'b0;
    jump_en      = 1'b0;
    bus.ir_ready = 1'b0;
    do_reset();
    m_pc      = '0;
    m_cnt     = '0;
    m_halted  = 1'b0;
    prev_req  = 1'b0;
    prev_halt = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      check("rnd_pc", PC, m_pc);
      check("rnd_cnt", instr_count, m_cnt);
      check("rnd_halted", halted, m_halted);
      if (bus.ir_valid) check("rnd_ir", bus.IR, mem[m_pc]);
      if (!prev_req && prev_halt) check("rnd_req_blocked", bus.imem_req, 0);
      if (bus.imem_req && !prev_req) check("rnd_req_addr", bus.imem_addr, m_pc);
      prev_req = bus.imem_req;

      halt_program = ($urandom_range(0, 7) == 0);
      jump_en      = ($urandom_range(0, 15) == 0);
      jump_addr    = 12'($urandom);
      bus.ir_ready = 1'($urandom_range(0, 1));
      prev_halt    = halt_program;

      if (!m_halted) begin
        if (jump_en) begin
          m_pc = jump_addr;
        end else if (bus.ir_valid && bus.ir_ready && !halt_program) begin
          m_cnt = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
          if (mem[m_pc][15:12] == 4'hF) m_halted = 1'b1;
          m_pc = m_pc + 12'd1;
        end
      end
      cyc(1);
    end
    check("rnd_progress", (instr_count > 16'd50), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
